// File: rtl/timed_slice_override_pkg.sv
// Shared types and the per-lane drive function for timed_slice_override.
package timed_slice_override_pkg;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    HIZ  = 2'd1,
    ZERO = 2'd2,
    ONE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Value an overridden lane takes; PASS falls back to the source bit.
  function automatic logic lane_value(mode_t m, logic a);
    case (m)
      HIZ:     return 1'bz;
      ZERO:    return 1'b0;
      ONE:     return 1'b1;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/timed_slice_override_hold_counter.sv
// Hold-cycle down counter: load, decrement, clear, last-cycle detect.
module slice_hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_remaining,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)                   cnt <= '0;
    else if (i_load)              cnt <= i_load_val;
    else if (i_clr)               cnt <= '0;
    else if (i_dec && cnt != '0)  cnt <= cnt - CNT_W'(1);
  end

  assign o_remaining = cnt;
  assign o_last      = (cnt == CNT_W'(1));

endmodule

// File: rtl/timed_slice_override.sv
// Timed override of lanes [HI:LO] of an unpacked array to Z/0/1, auto-released.
// Optional abort input enabled by defining TIMED_SLICE_OVERRIDE_ABORT_EN.
module timed_slice_override
  import timed_slice_override_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LO    = 0,
  parameter int HI    = 3,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_en,
`ifdef TIMED_SLICE_OVERRIDE_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic             i_a [WIDTH-1:0],
  output logic             o_a [WIDTH-1:0],
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  mode_t            i_req_mode,
  input  logic [HI-LO:0]   i_req_mask,
  input  logic [CNT_W-1:0] i_req_cycles,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_remaining
);

  if (LO < 0 || LO > HI || HI >= WIDTH) begin : g_bad_slice
    $error("timed_slice_override: need 0 <= LO <= HI < WIDTH");
  end

  state_t           state;
  mode_t            mode_q;
  logic [HI-LO:0]   mask_q;
  logic             accept;
  logic             in_hold;
  logic             last;
  logic             abort_hold;
  logic [CNT_W-1:0] load_val;

  assign accept   = i_req_valid && o_req_ready;
  assign in_hold  = (state == HOLD);
  // A zero-length request still gets one hold cycle.
  assign load_val = (i_req_cycles == '0) ? CNT_W'(1) : i_req_cycles;

`ifdef TIMED_SLICE_OVERRIDE_ABORT_EN
  assign abort_hold = in_hold && i_abort;
`else
  assign abort_hold = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state  <= IDLE;
      mode_q <= PASS;
      mask_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state  <= HOLD;
          mode_q <= i_req_mode;
          mask_q <= i_req_mask;
        end
        HOLD:    if (last || abort_hold) state <= RELEASE;
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  slice_hold_counter #(.CNT_W(CNT_W)) u_cnt (
    .i_clk       (i_clk),
    .i_arst      (i_arst),
    .i_load      (accept),
    .i_load_val  (load_val),
    .i_dec       (in_hold),
    .i_clr       (abort_hold),
    .o_remaining (o_remaining),
    .o_last      (last)
  );

  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_done      = (state == RELEASE);

  for (genvar j = 0; j < WIDTH; j++) begin : g_lane
    if (j >= LO && j <= HI) begin : g_ovr
      logic ovr;
      assign ovr    = in_hold && i_en && (mode_q != PASS) && mask_q[j-LO];
      assign o_a[j] = ovr ? lane_value(mode_q, i_a[j]) : i_a[j];
    end else begin : g_pass
      assign o_a[j] = i_a[j];
    end
  end

endmodule
